lcd_cmd_seq: RTL

- Upstream command sequencer for the LCD image controller. Stores a short command script, then replays it on cmd/cmd_valid, honouring the controller's busy handshake.
- Ends the run on the first WRITE command, after the controller reports done.
- Sits between the testbench/host programming port and the controller's cmd, cmd_valid, busy and done pins.

---
 rtl/lcd_pkg.sv | 20 ++
 rtl/lcd_cmd_mem.sv | 22 ++
 rtl/lcd_cmd_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared command codes and sequencer state encoding for the LCD command sequencer.
package lcd_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_AVG   = 3'd5;
  localparam logic [2:0] CMD_MIRX  = 3'd6;
  localparam logic [2:0] CMD_MIRY  = 3'd7;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_RDY  = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

endpackage

// File: rtl/lcd_cmd_mem.sv
// Command script storage: one synchronous write port, one combinational read port.
module lcd_cmd_mem #(
  parameter int CMD_DEPTH = 16,
  parameter int AW        = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [2:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [2:0]    rdata_o
);

  logic [2:0] mem_q [CMD_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_cmd_seq.sv
// Replays a stored command script to the LCD controller, pacing issues on its
// busy handshake and stopping after the first WRITE once the controller is done.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int         CMD_DEPTH = 16,
  parameter int         AW        = 4,
  parameter int         GAP       = 2,
  parameter logic [2:0] IDLE_CMD  = 3'd1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [2:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          busy,
  input  logic          done_in,
  output logic [2:0]    cmd,
  output logic          cmd_valid,
  output logic          seq_busy,
  output logic          seq_done,
  output logic          truncated,
  output logic [AW:0]   issued_cnt
);

  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  logic [2:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    cur_q, cur_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          trunc_q, trunc_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [AW-1:0] shadow_addr_q, shadow_addr_d;
  logic          shadow_vld_q, shadow_vld_d;

  logic          in_idle, addr_ok, len_ok, mem_we, start_ok, at_last;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data, issue_code;

  assign in_idle  = (state_q == S_IDLE);
  assign addr_ok  = int'(prog_addr) < CMD_DEPTH;
  assign len_ok   = (prog_len != '0) && (int'(prog_len) <= CMD_DEPTH);
  assign mem_we   = in_idle && prog_we && addr_ok;
  assign start_ok = in_idle && start && len_ok;
  assign at_last  = ({1'b0, ptr_q} == (len_q - (AW+1)'(1)));

  // The read port looks at prog_addr while idle so a write colliding with
  // start can preserve the pre-write entry for this run.
  assign rd_addr    = in_idle ? prog_addr : ptr_q;
  assign issue_code = (shadow_vld_q && (shadow_addr_q == ptr_q)) ? shadow_q : rd_data;

  lcd_cmd_mem #(
    .CMD_DEPTH (CMD_DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    ptr_d         = ptr_q;
    gap_d         = gap_q;
    cur_d         = cur_q;
    cnt_d         = cnt_q;
    trunc_d       = trunc_q;
    shadow_d      = shadow_q;
    shadow_addr_d = shadow_addr_q;
    shadow_vld_d  = shadow_vld_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          len_d         = prog_len;
          ptr_d         = '0;
          cnt_d         = '0;
          trunc_d       = 1'b0;
          shadow_d      = rd_data;
          shadow_addr_d = prog_addr;
          shadow_vld_d  = mem_we;
          state_d       = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (!busy) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cur_d   = issue_code;
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
        if (cnt_q < len_q) cnt_d = cnt_q + (AW+1)'(1);
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        // Leave on the cycle the counter reaches zero: GAP cycles in this state.
        if (gap_q <= GW'(1)) begin
          if (cur_q == CMD_WRITE) begin
            trunc_d = !at_last;
            state_d = S_WAIT_DONE;
          end else if (at_last) begin
            state_d = S_FINISH;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = S_WAIT_RDY;
          end
        end
      end
      S_WAIT_DONE: begin
        if (done_in) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      trunc_q      <= 1'b0;
      shadow_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trunc_q      <= trunc_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q         <= len_d;
    ptr_q         <= ptr_d;
    gap_q         <= gap_d;
    cur_q         <= cur_d;
    shadow_q      <= shadow_d;
    shadow_addr_q <= shadow_addr_d;
  end

  always_comb begin
    cmd = IDLE_CMD;
    case (state_q)
      S_ISSUE:            cmd = issue_code;
      S_GAP, S_WAIT_DONE: cmd = cur_q;
      default:            cmd = IDLE_CMD;
    endcase
  end

  assign cmd_valid  = (state_q == S_ISSUE);
  assign seq_busy   = !in_idle;
  assign seq_done   = (state_q == S_FINISH);
  assign truncated  = trunc_q;
  assign issued_cnt = cnt_q;

endmodule
